imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_pkg.sv | 21 ++
 rtl/imm_extract.sv | 39 +++
 rtl/imm_gen_pipe.sv | 95 +++++++++
 tb/tb_imm_gen_pipe.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared format-select encodings and datapath-width legality for the immediate generator.
package imm_pkg;

   typedef enum logic [2:0] {
      IMM_I   = 3'b000,
      IMM_S   = 3'b001,
      IMM_B   = 3'b010,
      IMM_J   = 3'b011,
      IMM_U   = 3'b100,
      IMM_Z   = 3'b101,
      IMM_ILL = 3'b110
   } imm_sel_e;

   localparam int XLEN_NARROW = 32;
   localparam int XLEN_WIDE   = 64;

   function automatic bit xlen_is_legal(input int xlen);
      return (xlen == XLEN_NARROW) || (xlen == XLEN_WIDE);
   endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational RISC-V immediate field extraction and extension.
// Define IMM_GEN_WORD_ADDR_EN to scale B/J offsets by 4 for a word-addressed PC.
module imm_extract
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   input  logic [2:0]      sel,
   output logic [XLEN-1:0] imm,
   output logic            illegal
);

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      imm     = '0;
      illegal = 1'b0;
      case (sel)
         IMM_I: imm = XLEN'($signed(instr[31:20]));
         IMM_S: imm = XLEN'($signed({instr[31:25], instr[11:7]}));
         IMM_B: begin
            imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
`ifdef IMM_GEN_WORD_ADDR_EN
            imm = imm << 2;
`endif
         end
         IMM_J: begin
            imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
`ifdef IMM_GEN_WORD_ADDR_EN
            imm = imm << 2;
`endif
         end
         IMM_U: imm = XLEN'($signed({instr[31:12], 12'b0}));
         IMM_Z: imm = XLEN'(instr[19:15]);
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator behind a valid/ready handshake with a head + skid buffer.
// IMM_GEN_WORD_ADDR_EN (see imm_extract) scales B/J offsets for a word-addressed PC.
module imm_gen_pipe
   import imm_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [2:0]       in_sel,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic             out_illegal,
   output logic [TAG_W-1:0] out_tag
);

   if (!xlen_is_legal(XLEN)) begin : g_xlen_check
      $error("imm_gen_pipe: XLEN must be 32 or 64");
   end

   typedef struct packed {
      logic [XLEN-1:0]  imm;
      logic             illegal;
      logic [TAG_W-1:0] tag;
   } entry_t;

   entry_t in_entry, head_q, head_d, skid_q, skid_d;
   logic   head_vld_q, head_vld_d, skid_vld_q, skid_vld_d, rdy_q;
   logic   accept, drain;

   imm_extract #(.XLEN(XLEN)) u_extract (
      .instr   (in_instr),
      .sel     (in_sel),
      .imm     (in_entry.imm),
      .illegal (in_entry.illegal)
   );
   assign in_entry.tag = in_tag;

   assign accept = in_valid & rdy_q;
   assign drain  = head_vld_q & out_ready;

   // The skid only fills while the head is stalled, so it always holds the younger entry.
   always_comb begin
      head_d     = head_q;
      head_vld_d = head_vld_q;
      skid_d     = skid_q;
      skid_vld_d = skid_vld_q;
      if (!head_vld_q || drain) begin
         if (skid_vld_q) begin
            head_d     = skid_q;
            head_vld_d = 1'b1;
            skid_vld_d = 1'b0;
         end else begin
            head_vld_d = accept;
            if (accept) head_d = in_entry;
         end
      end else if (accept) begin
         skid_d     = in_entry;
         skid_vld_d = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
         rdy_q      <= 1'b0;
         head_q     <= '0;
      end else begin
         head_vld_q <= head_vld_d;
         skid_vld_q <= skid_vld_d;
         rdy_q      <= !skid_vld_d;
         head_q     <= head_d;
      end
   end

   // NOTE: skid payload needs no reset; it is never observed unless skid_vld_q is set.
   always_ff @(posedge clk) begin
      skid_q <= skid_d;
   end

   assign in_ready    = rdy_q;
   assign out_valid   = head_vld_q;
   assign out_imm     = head_q.imm;
   assign out_illegal = head_q.illegal;
   assign out_tag     = head_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomized bench for imm_gen_pipe (XLEN=32 and XLEN=64 side by side) against a queue model.
module tb_imm_gen_pipe;
   import imm_pkg::*;

   localparam int TAG_W = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             out_ready = 1'b0;
   logic [31:0]      in_instr = '0;
   logic [2:0]       in_sel = '0;
   logic [TAG_W-1:0] in_tag = '0;

   logic             in_ready, out_valid, out_illegal;
   logic [31:0]      out_imm;
   logic [TAG_W-1:0] out_tag;
   logic             in_ready64, out_valid64, out_illegal64;
   logic [63:0]      out_imm64;
   logic [TAG_W-1:0] out_tag64;

   imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
      .out_illegal(out_illegal), .out_tag(out_tag)
   );

   imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
      .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag),
      .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
      .out_illegal(out_illegal64), .out_tag(out_tag64)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference immediate, built field by field with integer arithmetic.
   function automatic logic [63:0] ref_imm(input logic [31:0] instr, input logic [2:0] sel);
      longint x, v;
      x = longint'(instr);
      v = 0;
      case (sel)
         3'd0: begin v = (x >> 20) & 'hFFF; if (v >= 2048) v -= 4096; end
         3'd1: begin
            v = (((x >> 25) & 'h7F) << 5) | ((x >> 7) & 'h1F);
            if (v >= 2048) v -= 4096;
         end
         3'd2: begin
            v = (((x >> 31) & 1) << 12) | (((x >> 7) & 1) << 11)
              | (((x >> 25) & 'h3F) << 5) | (((x >> 8) & 'hF) << 1);
            if (v >= 4096) v -= 8192;
`ifdef IMM_GEN_WORD_ADDR_EN
            v = v * 4;
`endif
         end
         3'd3: begin
            v = (((x >> 31) & 1) << 20) | (((x >> 12) & 'hFF) << 12)
              | (((x >> 20) & 1) << 11) | (((x >> 21) & 'h3FF) << 1);
            if (v >= 1048576) v -= 2097152;
`ifdef IMM_GEN_WORD_ADDR_EN
            v = v * 4;
`endif
         end
         3'd4: begin v = x & 'hFFFFF000; if (v >= 64'sh80000000) v -= 64'sh100000000; end
         3'd5: v = (x >> 15) & 'h1F;
         default: v = 0;
      endcase
      return v;
   endfunction

   typedef struct {
      logic [63:0]      imm;
      logic             ill;
      logic [TAG_W-1:0] tag;
   } exp_t;

   exp_t q[$];
   bit   started = 1'b0;
   bit   last_rst = 1'b0;

   // Compare process: the queue length is the occupancy the block must show.
   always @(negedge clk) begin
      if (started && last_rst) begin
         check("rst_out_valid", out_valid, 0);
         check("rst_in_ready", in_ready, 0);
         check("rst_out_imm", out_imm, 0);
         check("rst_out_illegal", out_illegal, 0);
         check("rst_out_tag", out_tag, 0);
         check("rst_out_valid64", out_valid64, 0);
         check("rst_out_imm64", out_imm64, 0);
      end else if (started) begin
         check("in_ready", in_ready, q.size() < 2);
         check("in_ready64", in_ready64, q.size() < 2);
         check("out_valid", out_valid, q.size() > 0);
         check("out_valid64", out_valid64, q.size() > 0);
         if (out_valid && q.size() > 0) begin
            check("out_imm", out_imm, {32'b0, q[0].imm[31:0]});
            check("out_illegal", out_illegal, q[0].ill);
            check("out_tag", out_tag, q[0].tag);
            check("out_imm64", out_imm64, q[0].imm);
            check("out_illegal64", out_illegal64, q[0].ill);
            check("out_tag64", out_tag64, q[0].tag);
         end
      end
      if (!rst_n) begin
         started  = 1'b1;
         last_rst = 1'b1;
         q.delete();
      end else begin
         last_rst = 1'b0;
         if (started) begin
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready)
               q.push_back('{imm: ref_imm(in_instr, in_sel), ill: (in_sel >= 3'd6), tag: in_tag});
         end
      end
   end

   int or_mode = 0;  // 0: hold low, 1: hold high, 2: random
   initial forever begin
      @(posedge clk);
      #1;
      case (or_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic send(input logic [31:0] instr, input logic [2:0] sel, input logic [TAG_W-1:0] tag);
      bit acc = 1'b0;
      in_valid = 1'b1;
      in_instr = instr;
      in_sel   = sel;
      in_tag   = tag;
      for (int k = 0; k < 100 && !acc; k++) begin
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      check("send_accepted", acc, 1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      // Pin the model with hand-computed values.
      check("model_I", ref_imm(32'hFFF00093, IMM_I), 64'hFFFF_FFFF_FFFF_FFFF);
`ifdef IMM_GEN_WORD_ADDR_EN
      check("model_B", ref_imm(32'hFE000EE3, IMM_B), 64'hFFFF_FFFF_FFFF_FFF0);
`else
      check("model_B", ref_imm(32'hFE000EE3, IMM_B), 64'hFFFF_FFFF_FFFF_FFFC);
`endif
      check("model_U", ref_imm(32'h12345037, IMM_U), 64'h0000_0000_1234_5000);
      check("model_U_neg", ref_imm(32'h80000037, IMM_U), 64'hFFFF_FFFF_8000_0000);
      check("model_Z", ref_imm(32'h000F8073, IMM_Z), 64'h1F);
      check("model_S", ref_imm(32'hFE000FA3, IMM_S), 64'hFFFF_FFFF_FFFF_FFFF);

      rst_n = 1'b0;
      idle(3);
      rst_n = 1'b1;
      idle(1);
      check("ready_after_release", in_ready, 1);

      // Directed formats, output always ready.
      or_mode = 1;
      send(32'hFFF00093, IMM_I, 4'd1);
      send(32'hFE000EE3, IMM_B, 4'd2);
      send(32'h12345037, IMM_U, 4'd3);
      send(32'h80000037, IMM_U, 4'd4);
      send(32'hDEADBEEF, IMM_ILL, 4'd5);
      send(32'h000F8073, IMM_Z, 4'd6);
      send(32'hFFFFFFFF, 3'b111, 4'd7);
      send(32'h800000EF, IMM_J, 4'd8);
      idle(4);

      // Three back-to-back requests against a stalled consumer.
      or_mode = 0;
      idle(1);
      send(32'h00100093, IMM_I, 4'd1);
      send(32'h00200093, IMM_I, 4'd2);
      check("ready_low_when_full", in_ready, 0);
      fork
         send(32'h00300093, IMM_I, 4'd3);
         begin
            repeat (3) @(posedge clk);
            or_mode = 1;
         end
      join
      idle(5);

      // Reset with both entries full: nothing buffered may reappear.
      or_mode = 0;
      idle(1);
      send(32'h7FF00093, IMM_I, 4'd9);
      send(32'h7FF00093, IMM_S, 4'd10);
      rst_n = 1'b0;
      idle(1);
      check("reset_clears_valid", out_valid, 0);
      check("reset_clears_ready", in_ready, 0);
      rst_n = 1'b1;
      idle(1);
      check("ready_after_midreset", in_ready, 1);
      or_mode = 1;
      idle(5);

      // Randomized traffic with random backpressure and one mid-run reset.
      or_mode = 2;
      for (int i = 0; i < 400; i++) begin
         send($urandom, 3'($urandom_range(0, 7)), TAG_W'($urandom));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         if (i == 200) begin
            rst_n = 1'b0;
            idle(1);
            rst_n = 1'b1;
            idle(1);
         end
      end

      or_mode = 1;
      for (int k = 0; k < 50 && q.size() > 0; k++) idle(1);
      check("drain_empty", q.size(), 0);
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
